// File: rtl/cam_pkg.sv
// Shared encodings for the OV7670 capture path: input formats, FSM states
// and a few RGB332 reference colours.
package cam_pkg;

    typedef enum logic [1:0] {
        FMT_RGB565 = 2'd0,
        FMT_RGB444 = 2'd1,
        FMT_YUV422 = 2'd2,
        FMT_RSVD   = 2'd3
    } fmt_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;

endpackage

// File: rtl/pixel_pack.sv
// Combinational reduction of a two-byte camera pixel to RGB332 or 8-bit grey.
module pixel_pack
    import cam_pkg::*;
(
    input  logic [7:0] hi,
    input  logic [7:0] lo,
    input  logic [1:0] format,
    output logic [7:0] pixel
);

    always_comb begin
        pixel = {hi[7:5], hi[2:0], lo[4:3]};
        case (fmt_t'(format))
            FMT_RGB444: pixel = {hi[3:1], lo[7:5], lo[3:2]};
            FMT_YUV422: pixel = hi;
            default:    pixel = {hi[7:5], hi[2:0], lo[4:3]};
        endcase
    end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame grabber: syncs to VSYNC/HREF, packs byte pairs into 8-bit
// pixels and emits RAM write strobes with optional 2x2 subsampling.
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int OUT_W  = 176,
    parameter int OUT_H  = 144,
    parameter int ADDR_W = 15
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        DATA_IN,
    input  logic [1:0]        FORMAT,
    input  logic              DECIM,
    input  logic              CAPTURE_EN,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output logic [7:0]        FRAME_CNT,
    output logic              LINE_OVF,
    output logic              FRAME_OVF
);

    // Source x saturates well above OUT_W so an over-long line keeps overflowing.
    localparam int XW = $clog2(2 * OUT_W + 2) + 1;
    localparam int YW = $clog2(OUT_H + 1);
    localparam logic [XW-1:0]     X_LIMIT   = XW'(OUT_W);
    localparam logic [YW-1:0]     Y_LIMIT   = YW'(OUT_H);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(OUT_W);

    state_t state_reg, state_next;

    logic              vsync_reg, href_reg, vsync_prev, href_prev;
    logic [7:0]        data_reg, hi_reg;
    logic              phase_reg;
    logic [XW-1:0]     x_reg, x_out;
    logic [YW-1:0]     y_reg;
    logic              y_odd_reg;
    logic [ADDR_W-1:0] line_base_reg;
    logic [1:0]        fmt_reg;
    logic              decim_reg;
    logic [7:0]        pixel;

    logic vsync_rise, vsync_fall, href_fall, pix_done, in_active;
    logic line_keep, x_keep, line_fits, x_fits, pix_ok;
    logic write_hit, line_ovf_hit, frame_ovf_hit;
    logic arm, start_frame, end_frame;

    pixel_pack u_pack (
        .hi     (hi_reg),
        .lo     (data_reg),
        .format (fmt_reg),
        .pixel  (pixel)
    );

    assign vsync_rise = vsync_reg & ~vsync_prev;
    assign vsync_fall = ~vsync_reg & vsync_prev;
    assign href_fall  = href_prev & ~href_reg;
    assign pix_done   = href_reg & phase_reg;
    assign in_active  = (state_reg == ACTIVE);

    assign x_out     = decim_reg ? (x_reg >> 1) : x_reg;
    assign x_keep    = ~decim_reg | ~x_reg[0];
    assign line_keep = ~y_odd_reg;
    assign line_fits = (y_reg < Y_LIMIT);
    assign x_fits    = (x_out < X_LIMIT);

    // Frame end wins over a pixel completing in the same cycle.
    assign pix_ok        = in_active & pix_done & ~vsync_rise & line_keep & x_keep;
    assign write_hit     = pix_ok & line_fits & x_fits;
    assign line_ovf_hit  = pix_ok & line_fits & ~x_fits;
    assign frame_ovf_hit = pix_ok & ~line_fits;

    assign arm         = (state_reg == IDLE) & CAPTURE_EN;
    assign start_frame = (state_reg == WAIT_SOF) & vsync_fall;
    assign end_frame   = in_active & vsync_rise;

    assign BUSY = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (CAPTURE_EN) state_next = WAIT_SOF;
            WAIT_SOF: if (vsync_fall) state_next = ACTIVE;
            ACTIVE:   if (vsync_rise) state_next = CAPTURE_EN ? WAIT_SOF : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_reg     <= 1'b0;
            href_reg      <= 1'b0;
            data_reg      <= 8'd0;
            vsync_prev    <= 1'b0;
            href_prev     <= 1'b0;
            phase_reg     <= 1'b0;
            hi_reg        <= 8'd0;
            x_reg         <= '0;
            y_reg         <= '0;
            y_odd_reg     <= 1'b0;
            line_base_reg <= '0;
            fmt_reg       <= 2'd0;
            decim_reg     <= 1'b0;
            W_ADDR        <= '0;
            W_DATA        <= 8'd0;
            W_EN          <= 1'b0;
            FRAME_DONE    <= 1'b0;
            FRAME_CNT     <= 8'd0;
            LINE_OVF      <= 1'b0;
            FRAME_OVF     <= 1'b0;
        end else begin
            vsync_reg  <= VSYNC;
            href_reg   <= HREF;
            data_reg   <= DATA_IN;
            vsync_prev <= vsync_reg;
            href_prev  <= href_reg;

            // A line ending on an odd byte leaves phase at 1; clearing it drops that byte.
            phase_reg <= href_reg ? ~phase_reg : 1'b0;
            if (href_reg && !phase_reg) begin
                hi_reg <= data_reg;
            end

            W_EN       <= write_hit;
            FRAME_DONE <= end_frame;
            if (write_hit) begin
                W_ADDR <= line_base_reg + ADDR_W'(x_out);
                W_DATA <= pixel;
            end
            if (end_frame) begin
                FRAME_CNT <= FRAME_CNT + 8'd1;
            end

            if (arm) begin
                LINE_OVF  <= 1'b0;
                FRAME_OVF <= 1'b0;
            end else begin
                if (line_ovf_hit)  LINE_OVF  <= 1'b1;
                if (frame_ovf_hit) FRAME_OVF <= 1'b1;
            end

            if (start_frame) begin
                x_reg         <= '0;
                y_reg         <= '0;
                y_odd_reg     <= 1'b0;
                line_base_reg <= '0;
                fmt_reg       <= FORMAT;
                decim_reg     <= DECIM;
            end else if (in_active) begin
                if (href_fall) begin
                    x_reg     <= '0;
                    y_odd_reg <= decim_reg & ~y_odd_reg;
                    if (line_keep && line_fits) begin
                        y_reg         <= y_reg + 1'b1;
                        line_base_reg <= line_base_reg + LINE_STEP;
                    end
                end else if (pix_done && (x_reg != '1)) begin
                    x_reg <= x_reg + 1'b1;
                end
            end
        end
    end

endmodule
